// File: rtl/regfile_pkg.sv
// Shared widths and the requester identifiers used by the write-back arbiter.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        REQ_WB = 1'b0,
        REQ_MC = 1'b1
    } req_id_e;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Busy scoreboard for multi-cycle destinations: set on issue, clear on write-back,
// two combinational lookups and a registered double-issue error pulse.
module reg_scoreboard
    import regfile_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  set_valid_i,
    input  logic [REG_ADDR_W-1:0] set_reg_i,
    input  logic                  clr_valid_i,
    input  logic [REG_ADDR_W-1:0] clr_reg_i,
    input  logic [REG_ADDR_W-1:0] q1_reg_i,
    input  logic [REG_ADDR_W-1:0] q2_reg_i,
    output logic                  q1_busy_o,
    output logic                  q2_busy_o,
    output logic                  iss_err_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                iss_err_q, iss_err_d;
    logic                clr_same;

    assign clr_same = clr_valid_i && (clr_reg_i == set_reg_i);

    // NOTE: every value is assigned at the top of the block so no path leaves a signal unassigned and infers a latch.
    always_comb begin
        busy_d    = busy_q;
        iss_err_d = 1'b0;
        if (clr_valid_i) begin
            busy_d[clr_reg_i] = 1'b0;
        end
        // The set is applied after the clear so a same-register collision leaves the bit busy.
        if (set_valid_i) begin
            busy_d[set_reg_i] = 1'b1;
            iss_err_d         = busy_q[set_reg_i] && !clr_same;
        end
        busy_d[0] = 1'b0;
    end

    // NOTE: the busy vector is reset as a whole; a stale bit would stall decode forever.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q    <= '0;
            iss_err_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            iss_err_q <= iss_err_d;
        end
    end

    assign q1_busy_o = busy_q[q1_reg_i];
    assign q2_busy_o = busy_q[q2_reg_i];
    assign iss_err_o = iss_err_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester arbiter for the register file write port with starvation escape.
// Optional same-cycle forwarding of the pending write is enabled with WB_BYPASS_EN.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
)
(
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [REG_ADDR_W-1:0] req0_reg,
    input  logic [DATA_W-1:0]     req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [REG_ADDR_W-1:0] req1_reg,
    input  logic [DATA_W-1:0]     req1_data,
    output logic                  req1_ready,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_reg,
    input  logic [REG_ADDR_W-1:0] q1_reg,
    input  logic [REG_ADDR_W-1:0] q2_reg,
    output logic                  q1_busy,
    output logic                  q2_busy,
    output logic                  iss_err,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0]     WriteData
`ifdef WB_BYPASS_EN
    ,
    output logic                  fwd1_hit,
    output logic                  fwd2_hit,
    output logic [DATA_W-1:0]     fwd1_data,
    output logic [DATA_W-1:0]     fwd2_data
`endif
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
    logic                  reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0]     write_data_q, write_data_d;
    logic                  grant_any;
    req_id_e               grant_id;
    logic [REG_ADDR_W-1:0] win_reg;
    logic [DATA_W-1:0]     win_data;

    always_comb begin
        grant_any = 1'b0;
        grant_id  = REQ_WB;
        if (!reset) begin
            if (req1_valid && starve_cnt_q == LIMIT) begin
                grant_any = 1'b1;
                grant_id  = REQ_MC;
            end else if (req0_valid) begin
                grant_any = 1'b1;
                grant_id  = REQ_WB;
            end else if (req1_valid) begin
                grant_any = 1'b1;
                grant_id  = REQ_MC;
            end
        end
    end

    assign req0_ready = grant_any && (grant_id == REQ_WB);
    assign req1_ready = grant_any && (grant_id == REQ_MC);
    assign win_reg    = (grant_id == REQ_MC) ? req1_reg  : req0_reg;
    assign win_data   = (grant_id == REQ_MC) ? req1_data : req0_data;

    always_comb begin
        starve_cnt_d = '0;
        if (req1_valid && !req1_ready) begin
            starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + CNT_W'(1);
        end
        // A write to register 0 is accepted but never reaches the register file.
        reg_write_d  = grant_any && (win_reg != REG_ZERO);
        write_reg_d  = reg_write_d ? win_reg  : write_reg_q;
        write_data_d = reg_write_d ? win_data : write_data_q;
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign RegWrite  = reg_write_q;
    assign WriteReg  = write_reg_q;
    assign WriteData = write_data_q;

    reg_scoreboard u_scoreboard (
        .clk_i       (Clk),
        .reset_i     (reset),
        .set_valid_i (iss_valid),
        .set_reg_i   (iss_reg),
        .clr_valid_i (req1_ready),
        .clr_reg_i   (req1_reg),
        .q1_reg_i    (q1_reg),
        .q2_reg_i    (q2_reg),
        .q1_busy_o   (q1_busy),
        .q2_busy_o   (q2_busy),
        .iss_err_o   (iss_err)
    );

`ifdef WB_BYPASS_EN
    assign fwd1_hit  = reg_write_q && (write_reg_q == q1_reg) && (q1_reg != REG_ZERO);
    assign fwd2_hit  = reg_write_q && (write_reg_q == q2_reg) && (q2_reg != REG_ZERO);
    assign fwd1_data = write_data_q;
    assign fwd2_data = write_data_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; forwarding checks compile only with WB_BYPASS_EN.
module tb_regfile_wb_arbiter;

    logic        Clk;
    logic        reset;
    logic        req0_valid, req1_valid, iss_valid;
    logic [4:0]  req0_reg, req1_reg, iss_reg, q1_reg, q2_reg;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready, q1_busy, q2_busy, iss_err;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
`ifdef WB_BYPASS_EN
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    regfile_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .Clk        (Clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_reg   (req0_reg),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_reg   (req1_reg),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .iss_valid  (iss_valid),
        .iss_reg    (iss_reg),
        .q1_reg     (q1_reg),
        .q2_reg     (q2_reg),
        .q1_busy    (q1_busy),
        .q2_busy    (q2_busy),
        .iss_err    (iss_err),
        .RegWrite   (RegWrite),
        .WriteReg   (WriteReg),
        .WriteData  (WriteData)
`ifdef WB_BYPASS_EN
        ,
        .fwd1_hit   (fwd1_hit),
        .fwd2_hit   (fwd2_hit),
        .fwd1_data  (fwd1_data),
        .fwd2_data  (fwd2_data)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 1'b0; req0_reg = '0; req0_data = '0;
        req1_valid = 1'b0; req1_reg = '0; req1_data = '0;
        iss_valid  = 1'b0; iss_reg  = '0;
        q1_reg = '0; q2_reg = '0;
        tick();
        tick();
        n_cmp++;
        if ({RegWrite, WriteReg, WriteData, iss_err} !== 39'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b/%0d/%h/%b want 0/0/0/0", RegWrite, WriteReg, WriteData, iss_err);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_readies: got %b%b want 00", req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_req0_only();
        req0_valid = 1'b1; req0_reg = 5'd8; req0_data = 32'h1;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL req0_only_ready: got %b%b want 10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        n_cmp++;
        if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'd8, 32'h1}) begin
            n_bad++;
            $display("FAIL req0_only_write: got %b/%0d/%h want 1/8/00000001", RegWrite, WriteReg, WriteData);
        end
        tick();
        n_cmp++;
        if ({RegWrite, WriteReg, WriteData} !== {1'b0, 5'd8, 32'h1}) begin
            n_bad++;
            $display("FAIL idle_hold: got %b/%0d/%h want 0/8/00000001", RegWrite, WriteReg, WriteData);
        end
    endtask

    task automatic test_starvation();
        logic exp1;
        for (int i = 0; i < 6; i++) begin
            req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 32'(i);
            req1_valid = 1'b1; req1_reg = 5'd5; req1_data = 32'hDEAD_0000 + 32'(i);
            exp1 = (i == 4);
            #1;
            n_cmp++;
            if ({req0_ready, req1_ready} !== {!exp1, exp1}) begin
                n_bad++;
                $display("FAIL starve_grant[%0d]: got %b%b want %b%b", i, req0_ready, req1_ready, !exp1, exp1);
            end
            tick();
            if (i == 4) begin
                n_cmp++;
                if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'd5, 32'hDEAD_0004}) begin
                    n_bad++;
                    $display("FAIL starve_req1_write: got %b/%0d/%h want 1/5/dead0004", RegWrite, WriteReg, WriteData);
                end
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_reg = 5'd18;
        tick();
        iss_valid = 1'b0;
        q1_reg = 5'd18; q2_reg = 5'd19;
        #1;
        n_cmp++;
        if ({q1_busy, q2_busy, iss_err} !== 3'b100) begin
            n_bad++;
            $display("FAIL sb_set: got busy1=%b busy2=%b err=%b want 1 0 0", q1_busy, q2_busy, iss_err);
        end
        iss_valid = 1'b1; iss_reg = 5'd18;
        tick();
        iss_valid = 1'b0;
        n_cmp++;
        if ({q1_busy, iss_err} !== 2'b11) begin
            n_bad++;
            $display("FAIL sb_double_issue: got busy=%b err=%b want 1 1", q1_busy, iss_err);
        end
        tick();
        n_cmp++;
        if (iss_err !== 1'b0) begin
            n_bad++;
            $display("FAIL sb_err_pulse: got err=%b want 0", iss_err);
        end
        req1_valid = 1'b1; req1_reg = 5'd18; req1_data = 32'h1234;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL req1_only_ready: got %b%b want 01", req0_ready, req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        n_cmp++;
        if ({q1_busy, RegWrite, WriteReg, WriteData} !== {1'b0, 1'b1, 5'd18, 32'h1234}) begin
            n_bad++;
            $display("FAIL sb_clear: got busy=%b %b/%0d/%h want 0 1/18/00001234", q1_busy, RegWrite, WriteReg, WriteData);
        end
        iss_valid = 1'b1; iss_reg = 5'd18;
        tick();
        req1_valid = 1'b1; req1_reg = 5'd18; req1_data = 32'h5678;
        tick();
        iss_valid = 1'b0; req1_valid = 1'b0;
        n_cmp++;
        if ({q1_busy, iss_err} !== 2'b10) begin
            n_bad++;
            $display("FAIL sb_set_wins: got busy=%b err=%b want 1 0", q1_busy, iss_err);
        end
    endtask

    task automatic test_reg_zero();
        req1_valid = 1'b1; req1_reg = 5'd0; req1_data = 32'hBEEF;
        #1;
        n_cmp++;
        if (req1_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reg0_ready: got %b want 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        n_cmp++;
        if (RegWrite !== 1'b0) begin
            n_bad++;
            $display("FAIL reg0_no_write: got RegWrite=%b want 0", RegWrite);
        end
        iss_valid = 1'b1; iss_reg = 5'd0;
        tick();
        tick();
        iss_valid = 1'b0;
        q2_reg = 5'd0;
        #1;
        n_cmp++;
        if ({q2_busy, iss_err} !== 2'b00) begin
            n_bad++;
            $display("FAIL reg0_busy: got busy=%b err=%b want 0 0", q2_busy, iss_err);
        end
    endtask

    task automatic test_reset_mid();
        q1_reg = 5'd18;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1; req0_reg = 5'd4; req0_data = 32'hA0 + 32'(i);
            req1_valid = 1'b1; req1_reg = 5'd6; req1_data = 32'hB0;
            tick();
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL mid_reset_readies: got %b%b want 00", req0_ready, req1_ready);
        end
        tick();
        n_cmp++;
        if ({RegWrite, WriteReg, WriteData, q1_busy, iss_err} !== 40'd0) begin
            n_bad++;
            $display("FAIL mid_reset_state: got %b/%0d/%h busy=%b err=%b want all 0", RegWrite, WriteReg, WriteData, q1_busy, iss_err);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL post_reset_grant: got %b%b want 10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_cmp++;
        if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'd4, 32'hA3}) begin
            n_bad++;
            $display("FAIL post_reset_write: got %b/%0d/%h want 1/4/000000a3", RegWrite, WriteReg, WriteData);
        end
        tick();
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        req0_valid = 1'b1; req0_reg = 5'd9; req0_data = 32'hA;
        tick();
        req0_valid = 1'b0;
        q1_reg = 5'd10; q2_reg = 5'd9;
        #1;
        n_cmp++;
        if ({fwd1_hit, fwd2_hit, fwd2_data} !== {1'b0, 1'b1, 32'hA}) begin
            n_bad++;
            $display("FAIL bypass: got hit1=%b hit2=%b data2=%h want 0 1 0000000a", fwd1_hit, fwd2_hit, fwd2_data);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_req0_only();
        test_starvation();
        test_scoreboard();
        test_reg_zero();
        test_reset_mid();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
